// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: per-source result FIFOs, round-robin grant, one registered broadcast per cycle.
// Optional feature: define CDB_BYPASS_EN to let a result skip its FIFO when every FIFO is empty (latency 1).
module cdb_arbiter #(
    parameter int NUM_SRC    = 4,
    parameter int DATA_W     = 32,
    parameter int TAG_W      = 5,
    parameter int FIFO_DEPTH = 2,
    parameter int SRC_W      = $clog2(NUM_SRC)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      flush,
    input  logic [NUM_SRC-1:0]        src_valid,
    input  logic [NUM_SRC*TAG_W-1:0]  src_tag,
    input  logic [NUM_SRC*DATA_W-1:0] src_data,
    output logic [NUM_SRC-1:0]        src_full,
    output logic                      bcast_valid,
    output logic [TAG_W-1:0]          bcast_tag,
    output logic [DATA_W-1:0]         bcast_data,
    output logic [SRC_W-1:0]          bcast_src,
    output logic                      overflow
);

    localparam int IDX_W = $clog2(FIFO_DEPTH);
    localparam int PTR_W = IDX_W + 1;

    // Handshake: a producer may present src_valid with a non-zero tag in any cycle;
    // the item is accepted at the edge only if src_full was low during that cycle,
    // otherwise it is lost and overflow latches. Consumers see one bcast_valid pulse per item.

    logic [TAG_W-1:0]   tag_mem  [NUM_SRC][FIFO_DEPTH];
    logic [DATA_W-1:0]  data_mem [NUM_SRC][FIFO_DEPTH];
    logic [PTR_W-1:0]   wr_ptr   [NUM_SRC];
    logic [PTR_W-1:0]   rd_ptr   [NUM_SRC];
    logic [SRC_W-1:0]   rr_ptr;

    logic [NUM_SRC-1:0] push_req;
    logic [NUM_SRC-1:0] fifo_empty;
    logic [NUM_SRC-1:0] fifo_full;
    logic [NUM_SRC-1:0] arb_req;
    logic [NUM_SRC-1:0] push_en;
    logic [NUM_SRC-1:0] pop_en;
    logic               bypass_sel;
    logic               overflow_set;
    logic               grant_valid;
    logic [SRC_W-1:0]   grant_idx;
    logic [SRC_W-1:0]   scan_idx;
    logic [TAG_W-1:0]   grant_tag;
    logic [DATA_W-1:0]  grant_data;

    // Full/empty come from the wrap bit of the extended pointers.
    always_comb begin : fifo_status
        fifo_empty = '0;
        fifo_full  = '0;
        push_req   = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            fifo_empty[i] = (wr_ptr[i] == rd_ptr[i]);
            fifo_full[i]  = (wr_ptr[i][IDX_W] != rd_ptr[i][IDX_W]) &&
                            (wr_ptr[i][IDX_W-1:0] == rd_ptr[i][IDX_W-1:0]);
            push_req[i]   = src_valid[i] && (src_tag[i*TAG_W +: TAG_W] != '0);
        end
    end

`ifdef CDB_BYPASS_EN
    assign bypass_sel = (&fifo_empty) && !flush;
`else
    assign bypass_sel = 1'b0;
`endif

    assign arb_req = bypass_sel ? push_req : ~fifo_empty;

    always_comb begin : rr_scan
        grant_valid = 1'b0;
        grant_idx   = '0;
        scan_idx    = '0;
        for (int off = 0; off < NUM_SRC; off++) begin
            scan_idx = SRC_W'((int'(rr_ptr) + off) % NUM_SRC);
            if (!grant_valid && arb_req[scan_idx]) begin
                grant_valid = 1'b1;
                grant_idx   = scan_idx;
            end
        end
    end

    // In bypass mode the granted item comes from the raw source lanes, not the FIFO head.
    always_comb begin : grant_mux
        grant_tag  = '0;
        grant_data = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (grant_idx == SRC_W'(i)) begin
                if (bypass_sel) begin
                    grant_tag  = src_tag[i*TAG_W +: TAG_W];
                    grant_data = src_data[i*DATA_W +: DATA_W];
                end else begin
                    grant_tag  = tag_mem[i][rd_ptr[i][IDX_W-1:0]];
                    grant_data = data_mem[i][rd_ptr[i][IDX_W-1:0]];
                end
            end
        end
    end

    always_comb begin : push_pop
        push_en = '0;
        pop_en  = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            push_en[i] = push_req[i] && !fifo_full[i] && !flush &&
                         !(bypass_sel && grant_valid && grant_idx == SRC_W'(i));
            pop_en[i]  = !bypass_sel && grant_valid && !flush &&
                         (grant_idx == SRC_W'(i));
        end
        overflow_set = (|(push_req & fifo_full)) && !flush;
    end

    always_ff @(posedge clk) begin : fifo_mem
        for (int i = 0; i < NUM_SRC; i++) begin
            if (push_en[i]) begin
                tag_mem[i][wr_ptr[i][IDX_W-1:0]]  <= src_tag[i*TAG_W +: TAG_W];
                data_mem[i][wr_ptr[i][IDX_W-1:0]] <= src_data[i*DATA_W +: DATA_W];
            end
        end
    end

    // Flush empties every FIFO but keeps rr_ptr, overflow and the last broadcast payload.
    always_ff @(posedge clk) begin : ctrl
        if (!rst) begin
            for (int i = 0; i < NUM_SRC; i++) begin
                wr_ptr[i] <= '0;
                rd_ptr[i] <= '0;
            end
            rr_ptr      <= '0;
            bcast_valid <= 1'b0;
            bcast_tag   <= '0;
            bcast_data  <= '0;
            bcast_src   <= '0;
            overflow    <= 1'b0;
        end else if (flush) begin
            for (int i = 0; i < NUM_SRC; i++) begin
                wr_ptr[i] <= '0;
                rd_ptr[i] <= '0;
            end
            bcast_valid <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_SRC; i++) begin
                if (push_en[i]) begin
                    wr_ptr[i] <= wr_ptr[i] + 1'b1;
                end
                if (pop_en[i]) begin
                    rd_ptr[i] <= rd_ptr[i] + 1'b1;
                end
            end
            bcast_valid <= grant_valid;
            if (grant_valid) begin
                bcast_tag  <= grant_tag;
                bcast_data <= grant_data;
                bcast_src  <= grant_idx;
                rr_ptr     <= (grant_idx == SRC_W'(NUM_SRC - 1)) ? '0 : grant_idx + 1'b1;
            end
            if (overflow_set) begin
                overflow <= 1'b1;
            end
        end
    end

    assign src_full = fifo_full;

endmodule
